// File: rtl/joy_serial_scan_pkg.sv
// -----------------------------------------------------------------------------
// joy_serial_scan_pkg
//
// Shared definitions for the serial joystick front-end:
//   - scan_state_t : scan FSM states (WAIT, LOAD, SHIFT_LO, SHIFT_HI, UPDATE)
//   - FRAME_W      : bits clocked out of the 74HC165 chain per scan
//   - STICK_W      : width of one stick's primary byte
//   - EXT_W        : width of one stick's extended button nibble
//   - BTN_*        : bit positions inside a primary joystick byte
//   - frame_of()   : converts the raw active-low chain word to active-high
// -----------------------------------------------------------------------------
package joy_serial_scan_pkg;

    localparam int FRAME_W = 16;
    localparam int STICK_W = 8;
    localparam int EXT_W   = 4;

    // Kempston-style bit layout of joy1 / joy2
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_FIRE1 = 4;
    localparam int BTN_FIRE2 = 5;
    localparam int BTN_FIRE3 = 6;
    localparam int BTN_START = 7;

    typedef enum logic [2:0] {
        ST_WAIT     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_UPDATE   = 3'd4
    } scan_state_t;

    // Buttons on the chain pull low when pressed; the core wants active-high.
    function automatic logic [FRAME_W-1:0] frame_of(input logic [FRAME_W-1:0] raw);
        return ~raw;
    endfunction

endpackage

// File: rtl/joy_serial_scan_tick_div.sv
// -----------------------------------------------------------------------------
// tick_div
//
// Free-running DIV-bit prescaler. `tick` is high for exactly one clock, on the
// clock where the counter wraps back to zero, i.e. once every 2^DIV clocks.
// The first tick after reset release therefore lands 2^DIV clocks later.
//
// Ports:
//   clock  in   core clock
//   reset  in   asynchronous active-low reset
//   tick   out  one-clock pulse every 2^DIV clocks
// -----------------------------------------------------------------------------
module tick_div #(
    parameter int DIV = 6
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    logic [DIV-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV'(1);
        end
    end

    // All ones now means zero on the next clock: this is the wrapping clock.
    assign tick = &cnt;

endmodule

// File: rtl/joy_serial_scan.sv
// -----------------------------------------------------------------------------
// joy_serial_scan
//
// Serial joystick front-end. Clocks two DB9 sticks out of a 74HC165-style
// PISO chain (16 bits per scan), alternating the select line between primary
// and extended buttons, debounces each select independently (two consecutive
// equal scans) and presents active-high bytes to the core.
//
// Parameters:
//   DIV     shift tick every 2^DIV clocks
//   SETTLE  ticks spent in WAIT after a joyS change before the next load
//           (must be >= 1)
//
// Ports:
//   clock      in   core clock
//   reset      in   asynchronous active-low reset
//   joyCk      out  chain shift clock, chain advances on its rising edge
//   joyLd      out  chain parallel load, active-low
//   joyS       out  select: 1 = primary buttons, 0 = extended buttons
//   joyD       in   chain serial data, buttons active-low
//   joy1/joy2  out  primary bytes, active-high (bit 0 right .. bit 7 start)
//   joy1x/2x   out  extended nibbles, active-high
//   strb       out  one-clock pulse whenever any joy output has changed
//   dbg_state  out  current scan FSM state
//
// Output protocol: joy1/joy2/joy1x/joy2x are registered and only change on
// the UPDATE tick clock; strb is high for exactly the one clock after such a
// change. There is no backpressure: a consumer that cares about changes must
// take the values while strb is high (they remain stable at least a scan).
// -----------------------------------------------------------------------------
module joy_serial_scan
    import joy_serial_scan_pkg::*;
#(
    parameter int DIV    = 6,
    parameter int SETTLE = 4
) (
    input  logic               clock,
    input  logic               reset,
    output logic               joyCk,
    output logic               joyLd,
    output logic               joyS,
    input  logic               joyD,
    output logic [STICK_W-1:0] joy1,
    output logic [STICK_W-1:0] joy2,
    output logic [EXT_W-1:0]   joy1x,
    output logic [EXT_W-1:0]   joy2x,
    output logic               strb,
    output scan_state_t        dbg_state
);

    localparam int WAIT_W = $clog2(SETTLE + 1);
    localparam int BIT_W  = $clog2(FRAME_W) + 1;

    // ------------------------------------------------------------------
    // Shift tick
    // ------------------------------------------------------------------
    logic tick;

    tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    scan_state_t        state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] sr;        // raw chain word, active-low
    logic [FRAME_W-1:0] prev_pri;  // last raw primary word
    logic [FRAME_W-1:0] prev_ext;  // last raw extended word
    logic               strb_pend;

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Update-tick helpers
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0] frame;
    logic               accept;
    logic               pri_changed;
    logic               ext_changed;
    logic [BIT_W-1:0]   bit_cnt_next;

    assign frame        = frame_of(sr);
    assign bit_cnt_next = bit_cnt + BIT_W'(1);

    // Comparing raw words is the same test as comparing inverted frames.
    always_comb begin
        accept = 1'b0;
        if (joyS) begin
            accept = (sr == prev_pri);
        end else begin
            accept = (sr == prev_ext);
        end
    end

    // First received bit lands in frame[15]; stick 1 is the upper byte.
    assign pri_changed = (frame[15:8] != joy1) || (frame[7:0] != joy2);
    assign ext_changed = (frame[11:8] != joy1x) || (frame[3:0] != joy2x);

    // ------------------------------------------------------------------
    // Scan FSM, shift register, debounce and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_WAIT;
            wait_cnt  <= '0;
            bit_cnt   <= '0;
            sr        <= '1;
            prev_pri  <= '1;
            prev_ext  <= '1;
            joyCk     <= 1'b0;
            joyLd     <= 1'b1;
            joyS      <= 1'b1;
            joy1      <= '0;
            joy2      <= '0;
            joy1x     <= '0;
            joy2x     <= '0;
            strb_pend <= 1'b0;
            strb      <= 1'b0;
        end else begin
            strb      <= strb_pend;
            strb_pend <= 1'b0;

            if (tick) begin
                case (state)
                    // After reset wait_cnt starts at 0, so the first WAIT
                    // lasts SETTLE+1 ticks: the select pins get one extra
                    // tick to settle after the asynchronous release. After
                    // an UPDATE it restarts at 1, giving SETTLE ticks.
                    ST_WAIT: begin
                        if (wait_cnt == WAIT_W'(SETTLE)) begin
                            wait_cnt <= '0;
                            joyLd    <= 1'b0;
                            state    <= ST_LOAD;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end

                    ST_LOAD: begin
                        joyLd   <= 1'b1;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT_LO;
                    end

                    // The chain output has been stable for a full tick
                    // since the last rise (or the load), so sample it now
                    // and raise the shift clock for the next bit.
                    ST_SHIFT_LO: begin
                        sr    <= {sr[FRAME_W-2:0], joyD};
                        joyCk <= 1'b1;
                        state <= ST_SHIFT_HI;
                    end

                    ST_SHIFT_HI: begin
                        joyCk   <= 1'b0;
                        bit_cnt <= bit_cnt_next;
                        if (bit_cnt_next == BIT_W'(FRAME_W)) begin
                            state <= ST_UPDATE;
                        end else begin
                            state <= ST_SHIFT_LO;
                        end
                    end

                    ST_UPDATE: begin
                        if (joyS) begin
                            prev_pri <= sr;
                            if (accept) begin
                                joy1      <= frame[15:8];
                                joy2      <= frame[7:0];
                                strb_pend <= pri_changed;
                            end
                        end else begin
                            prev_ext <= sr;
                            if (accept) begin
                                joy1x     <= frame[11:8];
                                joy2x     <= frame[3:0];
                                strb_pend <= ext_changed;
                            end
                        end
                        joyS     <= ~joyS;
                        wait_cnt <= WAIT_W'(1);
                        state    <= ST_WAIT;
                    end

                    default: begin
                        joyCk <= 1'b0;
                        joyLd <= 1'b1;
                        state <= ST_WAIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_joy_serial_scan.sv
// -----------------------------------------------------------------------------
// tb_joy_serial_scan
//
// Bench for joy_serial_scan. A behavioural 74HC165 chain feeds the default
// instance (DIV=6, SETTLE=4); a second instance (DIV=2, SETTLE=1) sees a
// released chain and is used for timing measurements. Each completed scan is
// judged against a scan-level model: frame = ~pattern, accepted when equal to
// the previous frame of the same select, outputs/strb derived from that.
// -----------------------------------------------------------------------------
module tb_joy_serial_scan;
    import joy_serial_scan_pkg::*;

    localparam int TICK = 64;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- main DUT ----------------
    logic        joyCk, joyLd, joyS, joyD, strb;
    logic [7:0]  joy1, joy2;
    logic [3:0]  joy1x, joy2x;
    scan_state_t dbg_state;

    joy_serial_scan #(.DIV(6), .SETTLE(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .joyCk     (joyCk),
        .joyLd     (joyLd),
        .joyS      (joyS),
        .joyD      (joyD),
        .joy1      (joy1),
        .joy2      (joy2),
        .joy1x     (joy1x),
        .joy2x     (joy2x),
        .strb      (strb),
        .dbg_state (dbg_state)
    );

    // ---------------- fast DUT (released chain) ----------------
    logic        f_joyCk, f_joyLd, f_joyS, f_strb;
    logic [7:0]  f_joy1, f_joy2;
    logic [3:0]  f_joy1x, f_joy2x;
    scan_state_t f_dbg_state;

    joy_serial_scan #(.DIV(2), .SETTLE(1)) dut_fast (
        .clock     (clock),
        .reset     (reset),
        .joyCk     (f_joyCk),
        .joyLd     (f_joyLd),
        .joyS      (f_joyS),
        .joyD      (1'b1),
        .joy1      (f_joy1),
        .joy2      (f_joy2),
        .joy1x     (f_joy1x),
        .joy2x     (f_joy2x),
        .strb      (f_strb),
        .dbg_state (f_dbg_state)
    );

    // ---------------- chain model ----------------
    logic [15:0] pat_pri;
    logic [15:0] pat_ext;
    logic [15:0] chain_sr = 16'hFFFF;
    logic [16:0] exp_q[$];    // {select, raw word} of every load seen

    always @(negedge joyLd or posedge joyCk) begin
        if (!joyLd) begin
            chain_sr = joyS ? pat_pri : pat_ext;
            exp_q.push_back({joyS, chain_sr});
        end else begin
            chain_sr = {chain_sr[14:0], 1'b1};
        end
    end

    assign joyD = chain_sr[15];

    // ---------------- monitors ----------------
    int   ck_rises    = 0;
    int   strb_pulses = 0;
    int   strb_hi     = 0;
    int   overlap     = 0;
    logic strb_prev   = 1'b0;

    always @(posedge joyCk) ck_rises++;

    always @(negedge clock) begin
        if (strb === 1'b1) strb_hi++;
        if (strb === 1'b1 && strb_prev !== 1'b1) strb_pulses++;
        strb_prev = strb;
        if (joyLd === 1'b0 && joyCk === 1'b1) overlap++;
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_joy1, exp_joy2;
    logic [3:0]  exp_joy1x, exp_joy2x;
    logic [15:0] prev_frame [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        exp_joy1      = '0;
        exp_joy2      = '0;
        exp_joy1x     = '0;
        exp_joy2x     = '0;
        prev_frame[0] = '0;
        prev_frame[1] = '0;
    endtask

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock);
            #1;
            if (joyLd === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called right after a load was seen; judges the scan once it has ended.
    task automatic finish_scan(input string tag);
        int          r0, s0, exp_delta;
        logic [16:0] e;
        logic [15:0] fr;
        logic        sel, chg;
        r0        = ck_rises;
        s0        = strb_pulses;
        exp_delta = 0;
        repeat (35 * TICK) @(posedge clock);
        #1;
        chk({tag, "_recorded"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            sel = e[16];
            fr  = ~e[15:0];
            chg = 1'b0;
            if (fr == prev_frame[sel]) begin
                if (sel) begin
                    chg      = ({exp_joy1, exp_joy2} != fr);
                    exp_joy1 = fr[15:8];
                    exp_joy2 = fr[7:0];
                end else begin
                    chg       = ({exp_joy1x, exp_joy2x} != {fr[11:8], fr[3:0]});
                    exp_joy1x = fr[11:8];
                    exp_joy2x = fr[3:0];
                end
            end
            prev_frame[sel] = fr;
            exp_delta = chg ? 1 : 0;
        end
        chk({tag, "_joy1"},  32'(joy1),  32'(exp_joy1));
        chk({tag, "_joy2"},  32'(joy2),  32'(exp_joy2));
        chk({tag, "_joy1x"}, 32'(joy1x), 32'(exp_joy1x));
        chk({tag, "_joy2x"}, 32'(joy2x), 32'(exp_joy2x));
        chk({tag, "_strb"},  32'(strb_pulses - s0), 32'(exp_delta));
        chk({tag, "_rises"}, 32'(ck_rises - r0), 32'd16);
    endtask

    task automatic do_scan(input string tag);
        bit ok;
        wait_load(ok);
        chk({tag, "_load"}, 32'(ok), 32'd1);
        finish_scan(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n, r0, hold, hi, lo;
        bit ok, f_prev;

        pat_pri = 16'hFFFF;
        pat_ext = 16'hFFFF;
        reset   = 1'b0;
        reset_model();

        repeat (3) @(posedge clock);
        #1;
        chk("rst_joyCk", 32'(joyCk), 32'd0);
        chk("rst_joyLd", 32'(joyLd), 32'd1);
        chk("rst_joyS",  32'(joyS),  32'd1);
        chk("rst_joy1",  32'(joy1),  32'd0);
        chk("rst_joy2",  32'(joy2),  32'd0);
        chk("rst_joy1x", 32'(joy1x), 32'd0);
        chk("rst_joy2x", 32'(joy2x), 32'd0);
        chk("rst_strb",  32'(strb),  32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_WAIT));

        @(negedge clock);
        reset = 1'b1;

        // Fast instance: first load after (1+1)*4 clocks, period 35*4.
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            n++;
            if (f_joyLd === 1'b0) break;
        end
        chk("fast_first_load", 32'(n), 32'd8);

        n = 0;
        f_prev = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1;
            n++;
            if (f_prev == 1'b1 && f_joyLd === 1'b0) break;
            f_prev = f_joyLd;
        end
        chk("fast_period", 32'(n), 32'd140);

        for (int i = 0; i < 100; i++) begin
            if (f_joyCk === 1'b1) break;
            @(posedge clock);
            #1;
        end
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (f_joyCk !== 1'b1) break;
            hi++;
            @(posedge clock);
            #1;
        end
        lo = 0;
        for (int i = 0; i < 100; i++) begin
            if (f_joyCk !== 1'b0) break;
            lo++;
            @(posedge clock);
            #1;
        end
        chk("fast_ck_high", 32'(hi), 32'd4);
        chk("fast_ck_low",  32'(lo), 32'd4);

        // Released chain: nothing changes.
        do_scan("idle_pri");
        do_scan("idle_ext");

        // Stick 1 up + fire1.
        pat_pri = 16'hE7FF;
        do_scan("up_pri1");
        do_scan("up_ext1");
        do_scan("up_pri2");
        do_scan("up_ext2");
        chk("up_joy1_value", 32'(joy1), 32'((1 << BTN_UP) | (1 << BTN_FIRE1)));

        // Single-scan glitch on stick 2 right.
        pat_pri = 16'hE7FE;
        do_scan("glitch_pri");
        do_scan("glitch_ext");
        pat_pri = 16'hE7FF;
        do_scan("glitch_rel_pri");
        do_scan("glitch_rel_ext");
        chk("glitch_joy2_value", 32'(joy2), 32'd0);

        // Extended buttons, seen only with joyS = 0.
        pat_ext = 16'h0E0F;
        do_scan("ext_pri1");
        do_scan("ext_ext1");
        do_scan("ext_pri2");
        do_scan("ext_ext2");
        chk("ext_joy1x_value", 32'(joy1x), 32'd1);

        // Reset in the middle of shifting.
        wait_load(ok);
        chk("mid_load", 32'(ok), 32'd1);
        r0 = ck_rises;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clock);
            #1;
            if (ck_rises - r0 >= 7) break;
        end
        chk("mid_rises_reached", 32'(ck_rises - r0 >= 7), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_joy1",  32'(joy1),  32'd0);
        chk("mid_joy2",  32'(joy2),  32'd0);
        chk("mid_joy1x", 32'(joy1x), 32'd0);
        chk("mid_joy2x", 32'(joy2x), 32'd0);
        chk("mid_joyCk", 32'(joyCk), 32'd0);
        chk("mid_joyLd", 32'(joyLd), 32'd1);
        chk("mid_joyS",  32'(joyS),  32'd1);
        chk("mid_strb",  32'(strb),  32'd0);
        reset_model();
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clock);
            #1;
            n++;
            if (joyLd === 1'b0) break;
        end
        chk("mid_reset_to_load", 32'(n), 32'(5 * TICK));
        finish_scan("post_reset");

        // Randomised patterns held for a random number of scans.
        hold = 0;
        for (int k = 0; k < 10; k++) begin
            if (hold == 0) begin
                pat_pri = 16'($urandom_range(0, 65535));
                pat_ext = 16'($urandom_range(0, 65535));
                if ($urandom_range(0, 3) == 0) pat_pri = 16'hFFFF;
                hold = int'($urandom_range(2, 5));
            end
            hold--;
            do_scan("rnd");
        end

        chk("ld_ck_overlap", 32'(overlap), 32'd0);
        chk("strb_width",    32'(strb_hi), 32'(strb_pulses));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
